// File: rtl/corelet_seq_pkg.sv
// Shared types and instruction-word layout for the corelet_seq sequencer.
package corelet_seq_pkg;

    localparam int INST_W = 35;
    localparam int ADDR_W = 11;
    localparam int CNT_W  = 8;

    localparam int INST_EXEC      = 0;
    localparam int INST_LOAD      = 1;
    localparam int INST_L0_WR     = 2;
    localparam int INST_L0_RD     = 3;
    localparam int INST_OFIFO_RD  = 6;
    localparam int INST_XADDR_LSB = 7;
    localparam int INST_XMEM_CEN  = 18;
    localparam int INST_XMEM_WEN  = 19;
    localparam int INST_PADDR_LSB = 20;
    localparam int INST_PMEM_CEN  = 31;
    localparam int INST_PMEM_WEN  = 32;
    localparam int INST_ACC       = 33;
    localparam int INST_MODE      = 34;

    // Both SRAMs deselected and write-disabled; every other field zero.
    localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

    typedef enum logic [3:0] {
        IDLE,
        W_LOAD,
        W_PUSH,
        W_SETTLE,
        A_LOAD,
        A_EXEC,
        DRAIN,
        O_READ,
        DONE
    } state_e;

endpackage

// File: rtl/corelet_seq_if.sv
// Start/instruction bus between the sequencer (master) and the corelet/testbench (slave).
// `define CORELET_SEQ_PERF_EN adds the cycle_cnt signal.
interface corelet_seq_if;

    logic                               start;
    logic                               ofifo_valid;
    logic [corelet_seq_pkg::INST_W-1:0] inst;
    logic                               busy;
    logic                               done;
    logic [3:0]                         kij_idx;

`ifdef CORELET_SEQ_PERF_EN
    logic [15:0]                        cycle_cnt;

    modport master (input start, ofifo_valid, output inst, busy, done, kij_idx, cycle_cnt);
    modport slave  (output start, ofifo_valid, input inst, busy, done, kij_idx, cycle_cnt);
`else
    modport master (input start, ofifo_valid, output inst, busy, done, kij_idx);
    modport slave  (output start, ofifo_valid, input inst, busy, done, kij_idx);
`endif

endinterface

// File: rtl/corelet_seq_phase_cnt.sv
// Loadable down-counter with zero flag; times every phase of the sequencer.
module corelet_seq_phase_cnt
    import corelet_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/corelet_seq.sv
// Weight-stationary corelet instruction sequencer: issues load/push/execute/drain per kernel index.
// `define CORELET_SEQ_PERF_EN adds a saturating busy-cycle counter (cycle_cnt).
module corelet_seq
    import corelet_seq_pkg::*;
#(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int LEN_KIJ = 9,
    parameter int LEN_NIJ = 16,
    parameter int W_BASE  = 1024
) (
    input logic           clk,
    input logic           reset,
    corelet_seq_if.master bus
);

    state_e            state_q, state_d;
    logic [3:0]        kij_q, kij_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, done_q;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]  cnt_load_val, cnt, t_idx;

    corelet_seq_phase_cnt u_phase_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // Each timed phase loads (length-1), except the SRAM loads which need one extra cycle for read latency.
    always_comb begin
        state_d      = state_q;
        kij_d        = kij_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        case (state_q)
            IDLE: if (bus.start) begin
                state_d = W_LOAD; kij_d = '0; cnt_load = 1'b1; cnt_load_val = CNT_W'(COL);
            end
            W_LOAD: if (cnt_zero) begin
                state_d = W_PUSH; cnt_load = 1'b1; cnt_load_val = CNT_W'(COL - 1);
            end else cnt_dec = 1'b1;
            W_PUSH: if (cnt_zero) begin
                state_d = W_SETTLE; cnt_load = 1'b1; cnt_load_val = CNT_W'(ROW + COL - 1);
            end else cnt_dec = 1'b1;
            W_SETTLE: if (cnt_zero) begin
                state_d = A_LOAD; cnt_load = 1'b1; cnt_load_val = CNT_W'(LEN_NIJ);
            end else cnt_dec = 1'b1;
            A_LOAD: if (cnt_zero) begin
                state_d = A_EXEC; cnt_load = 1'b1; cnt_load_val = CNT_W'(LEN_NIJ - 1);
            end else cnt_dec = 1'b1;
            A_EXEC: if (cnt_zero) state_d = DRAIN;
                    else cnt_dec = 1'b1;
            DRAIN: if (bus.ofifo_valid) begin
                state_d = O_READ; cnt_load = 1'b1; cnt_load_val = CNT_W'(LEN_NIJ - 1);
            end
            O_READ: if (bus.ofifo_valid) begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (kij_q == 4'(LEN_KIJ - 1)) begin
                    state_d = DONE;
                end else begin
                    state_d = W_LOAD; kij_d = kij_q + 4'd1;
                    cnt_load = 1'b1; cnt_load_val = CNT_W'(COL);
                end
            end
            DONE: begin
                state_d = IDLE; kij_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inst_d = IDLE_INST;
        t_idx  = '0;
        case (state_q)
            W_LOAD: begin
                t_idx = CNT_W'(COL) - cnt;
                if (!cnt_zero) begin
                    inst_d[INST_XMEM_CEN] = 1'b0;
                    inst_d[INST_XADDR_LSB +: ADDR_W] = ADDR_W'(W_BASE) + ADDR_W'(kij_q) * ADDR_W'(COL) + ADDR_W'(t_idx);
                end
                if (cnt != CNT_W'(COL)) inst_d[INST_L0_WR] = 1'b1;
            end
            W_PUSH: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_LOAD]  = 1'b1;
            end
            A_LOAD: begin
                t_idx = CNT_W'(LEN_NIJ) - cnt;
                if (!cnt_zero) begin
                    inst_d[INST_XMEM_CEN] = 1'b0;
                    inst_d[INST_XADDR_LSB +: ADDR_W] = ADDR_W'(t_idx);
                end
                if (cnt != CNT_W'(LEN_NIJ)) inst_d[INST_L0_WR] = 1'b1;
            end
            A_EXEC: begin
                inst_d[INST_L0_RD] = 1'b1;
                inst_d[INST_EXEC]  = 1'b1;
            end
            O_READ: begin
                t_idx = CNT_W'(LEN_NIJ - 1) - cnt;
                if (bus.ofifo_valid) begin
                    inst_d[INST_OFIFO_RD] = 1'b1;
                    inst_d[INST_PMEM_CEN] = 1'b0;
                    inst_d[INST_PMEM_WEN] = 1'b0;
                    inst_d[INST_PADDR_LSB +: ADDR_W] = ADDR_W'(kij_q) * ADDR_W'(LEN_NIJ) + ADDR_W'(t_idx);
                end
            end
            default: ;
        endcase
        inst_d[INST_XMEM_WEN] = 1'b1;
        inst_d[INST_ACC]      = 1'b0;
        inst_d[INST_MODE]     = 1'b0;
    end

    // inst trails the state by one cycle; busy/done/kij_idx are aligned with the state itself.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            kij_q   <= '0;
            inst_q  <= IDLE_INST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            kij_q   <= kij_d;
            inst_q  <= inst_d;
            busy_q  <= (state_d != IDLE) && (state_d != DONE);
            done_q  <= (state_d == DONE);
        end
    end

    assign bus.inst    = inst_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.kij_idx = kij_q;

`ifdef CORELET_SEQ_PERF_EN
    logic [15:0] cyc_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q <= '0;
        end else if ((state_q == IDLE) && bus.start) begin
            cyc_q <= '0;
        end else if (busy_q && (cyc_q != 16'hFFFF)) begin
            cyc_q <= cyc_q + 16'd1;
        end
    end

    assign bus.cycle_cnt = cyc_q;
`endif

endmodule

// File: tb/tb_corelet_seq.sv
// Randomized self-checking bench for corelet_seq: the expected instruction trace is built per pass from the phase rules.
// Build with CORELET_SEQ_PERF_EN defined to also check cycle_cnt.
module tb_corelet_seq;

    localparam int ROW     = 8;
    localparam int COL     = 8;
    localparam int LEN_KIJ = 9;
    localparam int LEN_NIJ = 16;
    localparam int W_BASE  = 1024;
    localparam logic [34:0] IDLE_WORD = 35'h1_800C_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    corelet_seq_if bus ();

    corelet_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checkCount = 0;
    int errorCount = 0;
    int expBusy;
    int pmemHits [0:2047];

    // One entry per sequencer-state cycle: the word that state issues, the ofifo_valid seen, and the kij.
    logic [34:0] stWord[$];
    bit          stValid[$];
    int          stKij[$];

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [34:0] mkWord(input bit exec, input bit load, input bit l0Wr, input bit l0Rd,
                                           input bit ofifoRd, input bit xmemCen, input int xAddr,
                                           input bit pmemCen, input bit pmemWen, input int pAddr);
        logic [34:0] w;
        w        = '0;
        w[0]     = exec;
        w[1]     = load;
        w[2]     = l0Wr;
        w[3]     = l0Rd;
        w[6]     = ofifoRd;
        w[17:7]  = xAddr[10:0];
        w[18]    = xmemCen;
        w[19]    = 1'b1;
        w[30:20] = pAddr[10:0];
        w[31]    = pmemCen;
        w[32]    = pmemWen;
        return w;
    endfunction

    task automatic pushCycle(input logic [34:0] w, input bit v, input int k);
        stWord.push_back(w);
        stValid.push_back(v);
        stKij.push_back(k);
    endtask

    task automatic buildModel(input int firstDrain, input int maxHold);
        int d;
        int h;
        logic [34:0] idleW;
        idleW = mkWord(0, 0, 0, 0, 0, 1, 0, 1, 1, 0);
        stWord.delete();
        stValid.delete();
        stKij.delete();
        expBusy = LEN_KIJ * ((COL + 1) + COL + (ROW + COL) + (LEN_NIJ + 1) + LEN_NIJ + 1 + LEN_NIJ);
        for (int k = 0; k < LEN_KIJ; k++) begin
            for (int t = 0; t <= COL; t++)
                pushCycle(mkWord(0, 0, t >= 1, 0, 0, t == COL, (t < COL) ? W_BASE + k * COL + t : 0, 1, 1, 0),
                          1'($urandom_range(0, 1)), k);
            for (int t = 0; t < COL; t++)
                pushCycle(mkWord(0, 1, 0, 1, 0, 1, 0, 1, 1, 0), 1'($urandom_range(0, 1)), k);
            for (int t = 0; t < ROW + COL; t++)
                pushCycle(idleW, 1'($urandom_range(0, 1)), k);
            for (int t = 0; t <= LEN_NIJ; t++)
                pushCycle(mkWord(0, 0, t >= 1, 0, 0, t == LEN_NIJ, (t < LEN_NIJ) ? t : 0, 1, 1, 0),
                          1'($urandom_range(0, 1)), k);
            for (int t = 0; t < LEN_NIJ; t++)
                pushCycle(mkWord(1, 0, 0, 1, 0, 1, 0, 1, 1, 0), 1'($urandom_range(0, 1)), k);
            d = (k == 0 && firstDrain >= 0) ? firstDrain : int'($urandom_range(0, 4));
            expBusy += d;
            for (int i = 0; i < d; i++) pushCycle(idleW, 1'b0, k);
            pushCycle(idleW, 1'b1, k);
            for (int t = 0; t < LEN_NIJ; t++) begin
                h = (maxHold > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, maxHold)) : 0;
                expBusy += h;
                for (int i = 0; i < h; i++) pushCycle(idleW, 1'b0, k);
                pushCycle(mkWord(0, 0, 0, 0, 1, 1, 0, 0, 0, k * LEN_NIJ + t), 1'b1, k);
            end
        end
    endtask

    // Run one pass against the prepared trace; stopAt >= 0 asserts reset in that cycle instead of finishing.
    task automatic applyStimulus(input int stopAt);
        int nLast;
        int busySeen;
        int writes;
        logic [34:0] expInst;
        nLast    = stWord.size();
        busySeen = 0;
        writes   = 0;
        for (int a = 0; a < 2048; a++) pmemHits[a] = 0;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int n = 0; n <= nLast + 1; n++) begin
            if (n > 0) begin
                @(posedge clk); #1;
            end
            expInst = (n == 0 || n == nLast + 1) ? IDLE_WORD : stWord[n-1];
            checkOutput($sformatf("inst@%0d", n), 64'(bus.inst), 64'(expInst));
            checkOutput($sformatf("busy@%0d", n), 64'(bus.busy), 64'(n < nLast));
            checkOutput($sformatf("done@%0d", n), 64'(bus.done), 64'(n == nLast));
            if (n < nLast) checkOutput($sformatf("kij_idx@%0d", n), 64'(bus.kij_idx), 64'(stKij[n]));
`ifdef CORELET_SEQ_PERF_EN
            if (n == 0) checkOutput("cycle_cnt cleared by start", 64'(bus.cycle_cnt), 64'(0));
`endif
            if (bus.busy === 1'b1) busySeen++;
            if (bus.inst[31] === 1'b0 && bus.inst[32] === 1'b0) begin
                writes++;
                pmemHits[bus.inst[30:20]]++;
            end
            if (n == stopAt) begin
                reset = 1'b1;
                bus.start = 1'b0;
                bus.ofifo_valid = 1'b0;
                #1;
                checkOutput("inst after reset", 64'(bus.inst), 64'(IDLE_WORD));
                checkOutput("busy after reset", 64'(bus.busy), 64'(0));
                checkOutput("done after reset", 64'(bus.done), 64'(0));
                checkOutput("kij_idx after reset", 64'(bus.kij_idx), 64'(0));
`ifdef CORELET_SEQ_PERF_EN
                checkOutput("cycle_cnt after reset", 64'(bus.cycle_cnt), 64'(0));
`endif
                #2;
                reset = 1'b0;
                return;
            end
            bus.ofifo_valid = (n < nLast) ? stValid[n] : 1'b0;
            bus.start = (n == nLast) ? 1'b1 : ((n < nLast) && ($urandom_range(0, 7) == 0));
        end
        bus.start = 1'b0;
        checkOutput("busy cycle count", 64'(busySeen), 64'(expBusy));
        for (int a = 0; a < LEN_KIJ * LEN_NIJ; a++)
            checkOutput($sformatf("pmem addr %0d written once", a), 64'(pmemHits[a]), 64'(1));
        checkOutput("pmem write total", 64'(writes), 64'(LEN_KIJ * LEN_NIJ));
`ifdef CORELET_SEQ_PERF_EN
        checkOutput("cycle_cnt total", 64'(bus.cycle_cnt), 64'(expBusy));
`endif
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ofifo_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("idle inst", 64'(bus.inst), 64'(IDLE_WORD));
            checkOutput("idle busy", 64'(bus.busy), 64'(0));
            checkOutput("idle done", 64'(bus.done), 64'(0));
            checkOutput("idle kij_idx", 64'(bus.kij_idx), 64'(0));
        end
        $display("[TB] pass 1: 20-cycle drain wait on kij 0, no read holds");
        buildModel(20, 0);
        applyStimulus(-1);
        $display("[TB] pass 2: random drain waits and mid-read holds");
        buildModel(-1, 3);
        applyStimulus(-1);
        $display("[TB] pass 3: reset asserted during A_EXEC of kij 0");
        buildModel(-1, 2);
        applyStimulus(55);
        $display("[TB] pass 4: restart after reset");
        buildModel(-1, 2);
        applyStimulus(-1);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
